// File: rtl/mux_arb_pkg.sv
// Shared constants for the 2:1 round-robin mux arbiter: the output-stage
// state encoding, the default word width and the statistics counter width.
package mux_arb_pkg;

    // Default width of each requester word and of the output word.
    localparam int DATA_W_DEF = 8;

    // Width of the optional per-requester grant counters.
    localparam int STATS_W = 16;

    // Output register occupancy.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/rr_pick_2.sv
// Two-way round-robin pick. This block is purely combinational: it turns the
// two valid bits and the last-served index into a one-hot grant and a select.
// When nothing is valid the select output is 0. The parent keeps the held
// select value for that case.
module rr_pick_2 (
    input  logic [1:0] valid,
    input  logic       last_served,
    output logic [1:0] grant,
    output logic       sel
);

    // Choose the winner. Under contention the requester that was not served
    // last gets the grant.
    always_comb begin
        // NOTE: every output is given a default first, so no path through the
        // case leaves a value unassigned. An unassigned path would infer a latch.
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_served ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign sel = grant[1];

endmodule : rr_pick_2

// File: rtl/mux_2x1_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 2:1 mux. It picks a
// requester, performs the valid/ready handshake and registers the chosen word
// in a one-entry output stage. That stage can drain and load in the same cycle.
// Optional feature macro: ARB_STATS_EN adds the 16-bit grant counters
// gnt_cnt0 and gnt_cnt1.
module mux_2x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic [1:0]        grant
`ifdef ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] gnt_cnt0,
    output logic [STATS_W-1:0] gnt_cnt1
`endif
);

    logic [0:0] state;
    logic       last_served;
    logic       sel_q;
    logic       pick_sel;
    logic [1:0] pick_grant;
    logic       can_load;
    logic       xfer0;
    logic       xfer1;

    rr_pick_2 u_pick (
        .valid       ({req1_valid, req0_valid}),
        .last_served (last_served),
        .grant       (pick_grant),
        .sel         (pick_sel)
    );

    // The grant follows the valid inputs. The select keeps its last value
    // while no requester is valid.
    assign grant = pick_grant;
    assign sel   = (|pick_grant) ? pick_sel : sel_q;

    // The output register can take a word when it is empty or is being
    // drained in this same cycle.
    assign can_load   = (state == EMPTY) || out_ready;
    assign req0_ready = grant[0] && can_load;
    assign req1_ready = grant[1] && can_load;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;

    assign out_valid  = (state == FULL);

    // Hold the select across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together from the values sampled before the clock edge.
        if (!rst_n) sel_q <= 1'b0;
        else        sel_q <= sel;
    end

    // Output stage: load on a transfer, empty on a drain without a load,
    // and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_data    <= '0;
            last_served <= 1'b1;
        end else if (xfer0 || xfer1) begin
            state       <= FULL;
            out_data    <= xfer1 ? req1_data : req0_data;
            last_served <= xfer1;
        end else if (out_ready) begin
            state       <= EMPTY;
        end
    end

`ifdef ARB_STATS_EN
    // Per-requester transfer counters. They wrap naturally at 2^STATS_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (xfer0) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (xfer1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule : mux_2x1_rr_arbiter

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Self-checking bench for mux_2x1_rr_arbiter. A small reference model runs in
// step(). It predicts grant, select and readies each cycle and pushes each
// accepted word into a scoreboard queue. Words are popped and compared when
// the output stage shows them. The scenario tasks add their own targeted checks.
module tb_mux_2x1_rr_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         sel;
    logic [1:0]   grant;
`ifdef ARB_STATS_EN
    logic [15:0]  gnt_cnt0, gnt_cnt1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    logic         m_full;
    logic         m_last;
    logic         m_sel;
    logic [W-1:0] sb_q[$];

    always #5 clk = ~clk;

    mux_2x1_rr_arbiter #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .grant      (grant)
`ifdef ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    task automatic model_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        m_sel  = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle. It is entered just after a negedge with inputs
    // already driven, and it leaves at the next negedge.
    task automatic step();
        logic [1:0] eg;
        logic       cl;
        logic       x0, x1;
        #1;
        cl = !m_full || out_ready;
        case ({req1_valid, req0_valid})
            2'b01:   eg = 2'b01;
            2'b10:   eg = 2'b10;
            2'b11:   eg = m_last ? 2'b01 : 2'b10;
            default: eg = 2'b00;
        endcase
        if (eg != 2'b00) m_sel = eg[1];
        x0 = req0_valid && eg[0] && cl;
        x1 = req1_valid && eg[1] && cl;

        n_vec++;
        if (grant !== eg) begin
            n_bad++;
            $display("FAIL grant: got %b expected %b at %0t", grant, eg, $time);
        end
        n_vec++;
        if (sel !== m_sel) begin
            n_bad++;
            $display("FAIL sel: got %b expected %b at %0t", sel, m_sel, $time);
        end
        n_vec++;
        if ({req1_ready, req0_ready} !== {eg[1] && cl, eg[0] && cl}) begin
            n_bad++;
            $display("FAIL readies: got %b expected %b at %0t",
                     {req1_ready, req0_ready}, {eg[1] && cl, eg[0] && cl}, $time);
        end
        n_vec++;
        if (out_valid !== m_full) begin
            n_bad++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_full, $time);
        end
        if (m_full) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: empty queue while output full at %0t", $time);
            end else if (out_data !== sb_q[0]) begin
                n_bad++;
                $display("FAIL out_data: got %h expected %h at %0t", out_data, sb_q[0], $time);
            end
            if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
        end
        if (x0) sb_q.push_back(req0_data);
        if (x1) sb_q.push_back(req1_data);
        if (x0 || x1) begin
            m_full = 1'b1;
            m_last = x1;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle_drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hA5;
        req1_valid = 1'b1; req1_data = 8'h5A;
        out_ready  = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0 || grant !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b d=%h s=%b g=%b expected v=0 d=00 s=0 g=01",
                     out_valid, out_data, sel, grant);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL first_word: got v=%b d=%h expected v=1 d=a5", out_valid, out_data);
        end
        idle_drain();
    endtask

    task automatic test_single_req1();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h3C;
        out_ready  = 1'b1;
        #1;
        n_vec++;
        if (grant !== 2'b10 || sel !== 1'b1 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single_req1: got g=%b s=%b r1=%b r0=%b expected g=10 s=1 r1=1 r0=0",
                     grant, sel, req1_ready, req0_ready);
        end
        step();
        n_vec++;
        if (out_data !== 8'h3C || req0_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single_req1_out: got d=%h r0=%b expected d=3c r0=0", out_data, req0_ready);
        end
        idle_drain();
    endtask

    task automatic test_alternate();
        logic [W-1:0] exp_d[6] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
        logic [1:0]   exp_g[6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if (grant !== exp_g[i]) begin
                n_bad++;
                $display("FAIL alt_grant[%0d]: got %b expected %b", i, grant, exp_g[i]);
            end
            step();
            n_vec++;
            if (out_data !== exp_d[i]) begin
                n_bad++;
                $display("FAIL alt_data[%0d]: got %h expected %h", i, out_data, exp_d[i]);
            end
        end
        idle_drain();
    endtask

    task automatic test_hold();
        req0_valid = 1'b1; req0_data = 8'h44;
        req1_valid = 1'b1; req1_data = 8'h55;
        out_ready  = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_data !== 8'h44) begin
                n_bad++;
                $display("FAIL hold[%0d]: got r0=%b r1=%b d=%h expected r0=0 r1=0 d=44",
                         i, req0_ready, req1_ready, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            n_bad++;
            $display("FAIL drain_load: got v=%b d=%h expected v=1 d=55", out_valid, out_data);
        end
        idle_drain();
    endtask

    task automatic test_midreset();
        req0_valid = 1'b1; req0_data = 8'h77;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        step();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b d=%h expected v=0 d=00", out_valid, out_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h81;
        req1_valid = 1'b1; req1_data = 8'h82;
        out_ready  = 1'b1;
        step();
        n_vec++;
        if (out_data !== 8'h81) begin
            n_bad++;
            $display("FAIL post_reset_winner: got %h expected 81", out_data);
        end
        idle_drain();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h01;
        for (int i = 0; i < 5; i++) step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h02;
        for (int i = 0; i < 3; i++) step();
        req1_valid = 1'b0;
        step();
        n_vec++;
        if (gnt_cnt0 !== 16'd5 || gnt_cnt1 !== 16'd3) begin
            n_bad++;
            $display("FAIL stats_count: got c0=%0d c1=%0d expected c0=5 c1=3", gnt_cnt0, gnt_cnt1);
        end
        req0_valid = 1'b1;
        for (int i = 0; i < 65531; i++) @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd3) begin
            n_bad++;
            $display("FAIL stats_wrap: got c0=%0d c1=%0d expected c0=0 c1=3", gnt_cnt0, gnt_cnt1);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0;
        req1_valid = 1'b0; req1_data = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_req1();
        test_alternate();
        test_hold();
        test_midreset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mux_2x1_rr_arbiter
